din_burst_sched: RTL and testbench

Controller that sequences one input-feature-map load stage. On `start` it arms the serial-to-parallel BRAM writer (DIN_TRANS) through `stage_start`. It then issues AXI4 read bursts covering ROW_NUM rows of ROW_WORDS 32-bit words and drives the R-channel handshake that DIN_TRANS consumes as `axi_SHAKE`. It finishes by waiting for all 16 BRAM banks to report write-done and then pulses `done`.

---
 rtl/din_sched_pkg.sv | 23 ++
 rtl/din_rd_tracker.sv | 75 +++++++
 rtl/din_burst_sched.sv | 199 +++++++++++++++++++
 tb/tb_din_burst_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/din_sched_pkg.sv
// rtl/din_sched_pkg.sv - shared types and constants for the input-feature-map load scheduler
package din_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_WAIT_WDONE = 3'd4,
        ST_DONE       = 3'd5
    } sched_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam int         AXI_BEAT_BYTES = 1 << AXI_SIZE_4B;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    // Number of AXI read bursts needed to move one full stage.
    function automatic int total_bursts(input int row_num, input int row_words, input int burst_len);
        return (row_num * row_words) / burst_len;
    endfunction

endpackage

// File: rtl/din_rd_tracker.sv
// rtl/din_rd_tracker.sv - read-channel bookkeeping: outstanding bursts, beat position, protocol errors
module din_rd_tracker
    import din_sched_pkg::*;
#(
    parameter int BURST_LEN = 128,
    parameter int BCNT_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_ar_hs,
    input  logic              i_r_hs,
    input  logic              i_rlast,
    input  logic [1:0]        i_rresp,
    output logic [2:0]        o_outstanding,
    output logic [2:0]        o_outstanding_nxt,
    output logic [BCNT_W-1:0] o_r_done,
    output logic              o_err
);

    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [2:0]        r_outstanding;
    logic [BEAT_W-1:0] r_beat;
    logic [BCNT_W-1:0] r_r_done;

    logic w_retire;
    logic w_len_err;
    logic w_resp_err;
    logic w_orphan_err;

    // A burst only retires if one was actually in flight; an orphan RLAST is flagged instead.
    assign w_retire     = i_r_hs & i_rlast & (r_outstanding != 3'd0);
    assign w_len_err    = i_r_hs & ((i_rlast & (r_beat != LAST_BEAT)) | (~i_rlast & (r_beat == LAST_BEAT)));
    assign w_resp_err   = i_r_hs & (i_rresp != RESP_OKAY);
    assign w_orphan_err = i_r_hs & (r_outstanding == 3'd0);
    assign o_err        = w_len_err | w_resp_err | w_orphan_err;

    // Next outstanding count: an AR accept and a retiring RLAST in the same cycle cancel out.
    always_comb begin
        o_outstanding_nxt = r_outstanding;
        if (i_ar_hs && !w_retire) begin
            o_outstanding_nxt = r_outstanding + 3'd1;
        end else if (!i_ar_hs && w_retire) begin
            o_outstanding_nxt = r_outstanding - 3'd1;
        end
    end

    // Counters: outstanding bursts, beat index inside the current burst, retired bursts.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_outstanding <= 3'd0;
            r_beat        <= '0;
            r_r_done      <= '0;
        end else begin
            r_outstanding <= o_outstanding_nxt;
            if (i_r_hs) begin
                // A short or overlong burst restarts the beat count so later bursts are checked cleanly.
                if (i_rlast || (r_beat == LAST_BEAT)) begin
                    r_beat <= '0;
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
            if (w_retire) begin
                r_r_done <= r_r_done + BCNT_W'(1);
            end
        end
    end

    assign o_outstanding = r_outstanding;
    assign o_r_done      = r_r_done;

endmodule

// File: rtl/din_burst_sched.sv
// rtl/din_burst_sched.sv - sequences one input-feature-map load: arm writer, AXI read bursts, wait for bank write-done
module din_burst_sched
    import din_sched_pkg::*;
#(
    parameter int ROW_NUM         = 64,
    parameter int ROW_WORDS       = 384,
    parameter int BURST_LEN       = 128,
    parameter int MAX_OUTSTANDING = 2,
    parameter int WDONE_TIMEOUT   = 1024
) (
    input  logic        axi_ACLK,
    input  logic        axi_ARESET,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        stage_start,
    output logic [31:0] axi_ARADDR,
    output logic [7:0]  axi_ARLEN,
    output logic        axi_ARVALID,
    input  logic        axi_ARREADY,
    input  logic        axi_RVALID,
    input  logic        axi_RLAST,
    input  logic [1:0]  axi_RRESP,
    output logic        axi_RREADY,
    output logic        axi_SHAKE,
    input  logic [15:0] bram_wdone
);

    localparam int                TOTAL_BURSTS = total_bursts(ROW_NUM, ROW_WORDS, BURST_LEN);
    localparam int                BCNT_W       = $clog2(TOTAL_BURSTS + 1);
    localparam logic [BCNT_W-1:0] ALL_BURSTS   = BCNT_W'(TOTAL_BURSTS);
    localparam logic [BCNT_W-1:0] LAST_BURST   = BCNT_W'(TOTAL_BURSTS - 1);
    localparam logic [2:0]        MAX_OUT      = 3'(MAX_OUTSTANDING);
    localparam logic [31:0]       ADDR_STEP    = 32'(BURST_LEN * AXI_BEAT_BYTES);
    localparam int                TMO_W        = $clog2(WDONE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST     = TMO_W'(WDONE_TIMEOUT - 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic [BCNT_W-1:0] r_ar_issued;
    logic [BCNT_W-1:0] w_ar_issued_nxt;
    logic [31:0]       r_araddr;
    logic              r_arvalid;
    logic              r_err;
    logic [TMO_W-1:0]  r_wdone_cnt;

    logic              w_start_acc;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_rready;
    logic              w_busy;
    logic              w_done;
    logic              w_stage_start;
    logic              w_timeout;
    logic              w_trk_err;
    logic [2:0]        w_outstanding;
    logic [2:0]        w_outstanding_nxt;
    logic [BCNT_W-1:0] w_r_done;

    assign w_start_acc     = (r_state == ST_IDLE) & start;
    assign w_ar_hs         = r_arvalid & axi_ARREADY;
    assign w_r_hs          = axi_RVALID & w_rready;
    assign w_ar_issued_nxt = r_ar_issued + BCNT_W'(w_ar_hs);

    din_rd_tracker #(
        .BURST_LEN (BURST_LEN),
        .BCNT_W    (BCNT_W)
    ) u_rd_tracker (
        .i_clk             (axi_ACLK),
        .i_rst             (axi_ARESET),
        .i_clr             (w_start_acc),
        .i_ar_hs           (w_ar_hs),
        .i_r_hs            (w_r_hs),
        .i_rlast           (axi_RLAST),
        .i_rresp           (axi_RRESP),
        .o_outstanding     (w_outstanding),
        .o_outstanding_nxt (w_outstanding_nxt),
        .o_r_done          (w_r_done),
        .o_err             (w_trk_err)
    );

    // State register.
    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout     = 1'b0;
        w_busy        = 1'b1;
        w_done        = 1'b0;
        w_stage_start = 1'b0;
        w_rready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                // One quiet cycle with stage_start high lets the writer clear before data moves.
                w_stage_start = 1'b1;
                w_state_nxt   = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_stage_start = 1'b1;
                w_rready      = 1'b1;
                if (w_ar_hs && (r_ar_issued == LAST_BURST)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_stage_start = 1'b1;
                w_rready      = 1'b1;
                if ((w_outstanding == 3'd0) && (w_r_done == ALL_BURSTS)) begin
                    w_state_nxt = ST_WAIT_WDONE;
                end
            end
            ST_WAIT_WDONE: begin
                w_stage_start = 1'b1;
                if (&bram_wdone) begin
                    w_state_nxt = ST_DONE;
                end else if (r_wdone_cnt == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // AR channel: burst address and count, ARVALID judged against next-cycle counts so it holds until accepted.
    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            r_ar_issued <= '0;
            r_araddr    <= 32'd0;
            r_arvalid   <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_ar_issued <= '0;
                r_araddr    <= base_addr;
            end else if (w_ar_hs) begin
                r_ar_issued <= w_ar_issued_nxt;
                r_araddr    <= r_araddr + ADDR_STEP;
            end
            r_arvalid <= (w_state_nxt == ST_ISSUE) && (w_ar_issued_nxt < ALL_BURSTS)
                         && (w_outstanding_nxt < MAX_OUT);
        end
    end

    // Write-done wait timer, running only while in WAIT_WDONE.
    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            r_wdone_cnt <= '0;
        end else if (r_state == ST_WAIT_WDONE) begin
            r_wdone_cnt <= r_wdone_cnt + TMO_W'(1);
        end else begin
            r_wdone_cnt <= '0;
        end
    end

    // Sticky error: any read protocol fault or write-done timeout; cleared by the next accepted start.
    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_trk_err || w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign busy        = w_busy;
    assign done        = w_done;
    assign err         = r_err;
    assign stage_start = w_stage_start;
    assign axi_ARADDR  = r_araddr;
    assign axi_ARLEN   = 8'(BURST_LEN - 1);
    assign axi_ARVALID = r_arvalid;
    assign axi_RREADY  = w_rready;
    assign axi_SHAKE   = w_r_hs;

endmodule

// File: tb/tb_din_burst_sched.sv
// tb/tb_din_burst_sched.sv - directed self-checking bench for din_burst_sched
module tb_din_burst_sched;

    localparam int ROW_NUM   = 16;
    localparam int ROW_WORDS = 384;
    localparam int BURST_LEN = 128;
    localparam int MAX_OUT   = 2;
    localparam int WDONE_TO  = 1024;
    localparam int N_BURSTS  = 48;
    localparam int N_BEATS   = 6144;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        busy, done, err, stage_start;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic        rlast = 1'b0;
    logic [1:0]  rresp = 2'b00;
    logic        rready, shake;
    logic [15:0] bram_wdone = 16'h0;

    always #5 clk = ~clk;

    din_burst_sched #(
        .ROW_NUM         (ROW_NUM),
        .ROW_WORDS       (ROW_WORDS),
        .BURST_LEN       (BURST_LEN),
        .MAX_OUTSTANDING (MAX_OUT),
        .WDONE_TIMEOUT   (WDONE_TO)
    ) u_dut (
        .axi_ACLK    (clk),
        .axi_ARESET  (rst),
        .start       (start),
        .base_addr   (base_addr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .stage_start (stage_start),
        .axi_ARADDR  (araddr),
        .axi_ARLEN   (arlen),
        .axi_ARVALID (arvalid),
        .axi_ARREADY (arready),
        .axi_RVALID  (rvalid),
        .axi_RLAST   (rlast),
        .axi_RRESP   (rresp),
        .axi_RREADY  (rready),
        .axi_SHAKE   (shake),
        .bram_wdone  (bram_wdone)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave configuration
    int          ar_stall = 0;
    int          r_lat = 1;
    bit          sync_mode = 1'b0;
    int          short_burst = -1;
    int          short_beat = 0;
    int          resp_beat = -1;
    logic [15:0] wdone_val = 16'hFFFF;
    logic [31:0] exp_base = 32'd0;

    // monitor / slave state
    int          cyc = 0;
    int          ar_cnt, shake_cnt, bursts_done, outst, max_outst;
    int          addr_err, stab_err, shake_err, coinc_cnt, coinc_err;
    int          wait_entry = -1;
    int          done_cyc, done_cnt, g_beat, r_beat;
    int          stall_left = -1;
    bit          r_active, coinc_pend, prev_arv, prev_ardy, prev_rready;
    logic [31:0] prev_addr, last_addr;
    int          rq[$];

    task automatic clear_stats();
        ar_cnt = 0; shake_cnt = 0; bursts_done = 0; max_outst = 0;
        addr_err = 0; stab_err = 0; shake_err = 0; coinc_cnt = 0; coinc_err = 0;
        wait_entry = -1; done_cyc = 0; done_cnt = 0; g_beat = 0; last_addr = 32'd0;
    endtask

    initial begin : slave
        bit ar_rdy, rv, is_last, ar_hs, r_hs;
        int last_idx;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rq.delete();
                r_active = 1'b0; r_beat = 0; stall_left = -1; outst = 0;
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; bram_wdone = 16'h0;
                prev_arv = 1'b0; prev_rready = 1'b0; coinc_pend = 1'b0;
            end else begin
                if (prev_arv && !prev_ardy && (!arvalid || araddr !== prev_addr)) stab_err++;
                if (coinc_pend && !arvalid) coinc_err++;
                coinc_pend = 1'b0;
                if (prev_rready && !rready && busy && stage_start) wait_entry = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                bram_wdone = (wait_entry >= 0 && cyc >= wait_entry + 3) ? wdone_val : 16'h0;
                if (!r_active && rq.size() > 0 && rq[0] <= cyc) begin
                    void'(rq.pop_front());
                    r_active = 1'b1;
                    r_beat = 0;
                end
                last_idx = (bursts_done == short_burst) ? short_beat : BURST_LEN - 1;
                is_last = r_active && (r_beat == last_idx);
                rv = r_active;
                ar_rdy = 1'b0;
                if (sync_mode) begin
                    // accept an AR only together with a burst's last beat (or when nothing is in flight)
                    if (arvalid) ar_rdy = (outst == 0) || is_last;
                    if (is_last && !(arvalid && ar_rdy) && ar_cnt < N_BURSTS) rv = 1'b0;
                end else if (arvalid) begin
                    if (stall_left < 0) stall_left = ar_stall;
                    if (stall_left == 0) ar_rdy = 1'b1;
                    else stall_left--;
                end
                arready = ar_rdy;
                rvalid = rv;
                rlast = rv && is_last;
                rresp = (rv && g_beat == resp_beat) ? 2'b10 : 2'b00;
                #1;
                ar_hs = arvalid && ar_rdy;
                r_hs = rv && rready;
                if (shake !== r_hs) shake_err++;
                if (shake) shake_cnt++;
                if (ar_hs && r_hs && is_last && outst == 1) begin
                    coinc_cnt++;
                    coinc_pend = (ar_cnt + 1 < N_BURSTS);
                end
                if (ar_hs) begin
                    if (araddr !== exp_base + 32'(ar_cnt) * 32'h200) addr_err++;
                    last_addr = araddr;
                    ar_cnt++;
                    rq.push_back(cyc + r_lat);
                    stall_left = -1;
                end
                if (r_hs) begin
                    g_beat++;
                    if (is_last) begin
                        r_active = 1'b0;
                        bursts_done++;
                        outst--;
                    end else begin
                        r_beat++;
                    end
                end
                if (ar_hs) outst++;
                if (outst > max_outst) max_outst = outst;
                prev_arv = arvalid;
                prev_ardy = ar_rdy;
                prev_addr = araddr;
                prev_rready = rready;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic run_stage(input string name, input logic [31:0] base);
        clear_stats();
        exp_base = base;
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({name, "_arm"}, {60'd0, stage_start, arvalid, rready, err}, 64'h8);
        for (int i = 0; i < 20000 && done_cnt == 0; i++) tick();
        repeat (3) tick();
        check_eq({name, "_done_once"}, done_cnt, 1);
        check_eq({name, "_idle"}, {busy, stage_start}, 2'b00);
    endtask

    initial begin : main
        repeat (3) tick();
        check_eq("rst_ctrl", {busy, done, err, stage_start, arvalid, rready, shake}, 7'd0);
        check_eq("rst_araddr", araddr, 32'd0);
        check_eq("arlen", arlen, 8'd127);
        rst = 1'b0;
        tick();

        // nominal, always-ready slave
        run_stage("nom", 32'h1000_0000);
        check_eq("nom_ar_cnt", ar_cnt, N_BURSTS);
        check_eq("nom_last_addr", last_addr, 32'h1000_5E00);
        check_eq("nom_addr_err", addr_err, 0);
        check_eq("nom_shakes", shake_cnt, N_BEATS);
        check_eq("nom_shake_err", shake_err, 0);
        check_eq("nom_err", err, 0);
        check_eq("nom_done_lat", done_cyc - wait_entry, 4);
        check_eq("nom_max_outst", max_outst, 2);

        // AR backpressure and read latency
        ar_stall = 5; r_lat = 20;
        run_stage("bp", 32'h1000_0000);
        check_eq("bp_max_outst", max_outst, 2);
        check_eq("bp_stable", stab_err, 0);
        check_eq("bp_shakes", shake_cnt, N_BEATS);
        check_eq("bp_ar_cnt", ar_cnt, N_BURSTS);
        check_eq("bp_addr_err", addr_err, 0);
        check_eq("bp_err", err, 0);

        // AR accept coinciding with RLAST
        ar_stall = 0; r_lat = 1; sync_mode = 1'b1;
        run_stage("sync", 32'h0040_0000);
        check_eq("sync_coinc", coinc_cnt, 47);
        check_eq("sync_arvalid_after", coinc_err, 0);
        check_eq("sync_max_outst", max_outst, 1);
        check_eq("sync_shakes", shake_cnt, N_BEATS);
        check_eq("sync_stable", stab_err, 0);
        check_eq("sync_err", err, 0);
        sync_mode = 1'b0;

        // early RLAST at beat 100 of burst 3
        short_burst = 3; short_beat = 100;
        run_stage("short", 32'h1000_0000);
        check_eq("short_err", err, 1);
        check_eq("short_shakes", shake_cnt, N_BEATS - 27);
        check_eq("short_ar_cnt", ar_cnt, N_BURSTS);
        short_burst = -1;

        // error response on one beat
        resp_beat = 500;
        run_stage("resp", 32'h1000_0000);
        check_eq("resp_err", err, 1);
        check_eq("resp_shakes", shake_cnt, N_BEATS);
        resp_beat = -1;

        // write-done never complete
        wdone_val = 16'h7FFF;
        run_stage("tmo", 32'h1000_0000);
        check_eq("tmo_done_lat", done_cyc - wait_entry, WDONE_TO);
        check_eq("tmo_err", err, 1);
        wdone_val = 16'hFFFF;

        // reset in the middle of ISSUE, then a clean rerun
        resp_beat = 5;
        clear_stats();
        exp_base = 32'h1000_0000;
        base_addr = 32'h1000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2000 && ar_cnt < 3; i++) tick();
        check_eq("mid_ar_cnt", ar_cnt >= 3, 1);
        check_eq("mid_err_before_rst", err, 1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_ctrl", {busy, done, err, stage_start, arvalid, rready, shake}, 7'd0);
        check_eq("mid_rst_araddr", araddr, 32'd0);
        rst = 1'b0;
        resp_beat = -1;
        tick();
        run_stage("post_rst", 32'h2000_0000);
        check_eq("post_ar_cnt", ar_cnt, N_BURSTS);
        check_eq("post_last_addr", last_addr, 32'h2000_5E00);
        check_eq("post_shakes", shake_cnt, N_BEATS);
        check_eq("post_addr_err", addr_err, 0);
        check_eq("post_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
